// File: rtl/serial_pattern_tx.sv
// Serial pattern transmitter: captures a WIDTH-bit pattern on start and shifts it out MSB
// first, repeating it back-to-back for a captured count, then pulses done for one cycle.
module serial_pattern_tx #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned REPS_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [WIDTH-1:0]  pattern,
    input  logic [REPS_W-1:0] reps,
    input  logic              hold,
    output logic              bit_out,
    output logic              bit_valid,
    output logic              busy,
    output logic              done
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
    localparam logic [REPS_W-1:0] ONE_REP = REPS_W'(1);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

    state_e             state;
    logic [WIDTH-1:0]   shreg;
    logic [WIDTH-1:0]   pat_reg;
    logic [CNT_W-1:0]   bit_cnt;
    logic [REPS_W-1:0]  rep_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= StIdle;
            shreg   <= '0;
            pat_reg <= '0;
            bit_cnt <= '0;
            rep_cnt <= '0;
        end else begin
            case (state)
                StIdle: begin
                    if (start) begin
                        pat_reg <= pattern;
                        shreg   <= pattern;
                        bit_cnt <= '0;
                        rep_cnt <= reps;
                        state   <= (reps != '0) ? StShift : StDone;
                    end
                end
                StShift: begin
                    // hold freezes every register so the current bit is re-presented later
                    if (!hold) begin
                        shreg <= {shreg[WIDTH-2:0], 1'b0};
                        if (bit_cnt == LAST_BIT) begin
                            bit_cnt <= '0;
                            rep_cnt <= rep_cnt - ONE_REP;
                            if (rep_cnt == ONE_REP) begin
                                state <= StDone;
                            end else begin
                                shreg <= pat_reg;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                StDone: begin
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

    always_comb begin
        bit_out   = 1'b0;
        bit_valid = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            StShift: begin
                bit_out   = shreg[WIDTH-1];
                bit_valid = !hold;
                busy      = 1'b1;
            end
            StDone: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Randomised bench for serial_pattern_tx: a queue-of-bits model checked every cycle, plus
// literal expectations for the directed scenarios.
module tb_serial_pattern_tx;

    localparam int unsigned WIDTH  = 8;
    localparam int unsigned REPS_W = 4;

    logic              clk;
    logic              reset;
    logic              start;
    logic [WIDTH-1:0]  pattern;
    logic [REPS_W-1:0] reps;
    logic              hold;
    logic              bit_out;
    logic              bit_valid;
    logic              busy;
    logic              done;

    int checks;
    int failures;

    serial_pattern_tx #(
        .WIDTH  (WIDTH),
        .REPS_W (REPS_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .pattern   (pattern),
        .reps      (reps),
        .hold      (hold),
        .bit_out   (bit_out),
        .bit_valid (bit_valid),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the bits still to send, and whether a transmission (including its done cycle) is live.
    bit m_active;
    bit m_q[$];

    initial begin
        m_active = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                m_active = 1'b0;
                m_q.delete();
                chk("reset_outputs", {bit_out, bit_valid, busy, done}, 4'b0000);
            end else begin
                if (!m_active) begin
                    chk("idle_outputs", {bit_out, bit_valid, busy, done}, 4'b0000);
                end else if (m_q.size() > 0) begin
                    chk("shift_bit_out", bit_out, m_q[0]);
                    chk("shift_bit_valid", bit_valid, !hold);
                    chk("shift_busy_done", {busy, done}, 2'b10);
                end else begin
                    chk("done_outputs", {bit_out, bit_valid, busy, done}, 4'b0011);
                end
                // advance the model across the coming rising edge
                if (!m_active) begin
                    if (start) begin
                        m_active = 1'b1;
                        for (int r = 0; r < int'(reps); r++) begin
                            for (int i = WIDTH - 1; i >= 0; i--) m_q.push_back(pattern[i]);
                        end
                    end
                end else if (m_q.size() > 0) begin
                    if (!hold) void'(m_q.pop_front());
                end else begin
                    m_active = 1'b0;
                end
            end
        end
    end

    // Issue a start then run up to max_cyc cycles; cycle 1 is the first after the accepting edge.
    task automatic run(input logic [WIDTH-1:0] pat, input logic [REPS_W-1:0] r,
                       input logic [127:0] hmask, input logic [127:0] smask,
                       input bit rnd, input int max_cyc,
                       output int done_at, output int cap_n, output int busy_n,
                       output logic [127:0] cap);
        done_at = 0;
        cap_n   = 0;
        busy_n  = 0;
        cap     = '0;
        @(posedge clk);
        #1;
        start   = 1'b1;
        pattern = pat;
        reps    = r;
        hold    = 1'b0;
        for (int n = 1; n <= max_cyc; n++) begin
            @(posedge clk);
            #1;
            if (rnd) begin
                hold    = ($urandom_range(0, 3) == 0);
                start   = ($urandom_range(0, 7) == 0);
                pattern = WIDTH'($urandom);
                reps    = REPS_W'($urandom);
            end else begin
                hold    = hmask[n];
                start   = smask[n];
                pattern = '0;
                reps    = '0;
            end
            @(negedge clk);
            if (bit_valid) begin
                cap = {cap[126:0], bit_out};
                cap_n++;
            end
            if (busy) busy_n++;
            if (done) begin
                done_at = n;
                break;
            end
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        hold  = 1'b0;
    endtask

    int          d_at;
    int          c_n;
    int          b_n;
    logic [127:0] cap;

    initial begin
        reset   = 1'b1;
        start   = 1'b0;
        hold    = 1'b0;
        pattern = '0;
        reps    = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_state", {bit_out, bit_valid, busy, done}, 4'b0000);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // 1: single pattern
        run(8'b1011_0001, 4'd1, '0, '0, 1'b0, 40, d_at, c_n, b_n, cap);
        chk("s1_bits", cap[7:0], 8'b1011_0001);
        chk("s1_nbits", c_n, 8);
        chk("s1_done_at", d_at, 9);
        chk("s1_busy_cycles", b_n, 9);

        // 2: three back-to-back repeats
        run(8'hA5, 4'd3, '0, '0, 1'b0, 60, d_at, c_n, b_n, cap);
        chk("s2_bits", cap[23:0], 24'hA5A5A5);
        chk("s2_nbits", c_n, 24);
        chk("s2_done_at", d_at, 25);

        // 3: hold during the third and fourth cycles
        run(8'hF0, 4'd1, 128'h18, '0, 1'b0, 40, d_at, c_n, b_n, cap);
        chk("s3_bits", cap[7:0], 8'hF0);
        chk("s3_nbits", c_n, 8);
        chk("s3_done_at", d_at, 11);

        // 4: start re-pulsed in SHIFT (cycle 3) and DONE (cycle 9)
        run(8'hC3, 4'd1, '0, 128'h208, 1'b0, 40, d_at, c_n, b_n, cap);
        chk("s4_bits", cap[7:0], 8'hC3);
        chk("s4_done_at", d_at, 9);
        @(negedge clk);
        chk("s4_idle_after", {busy, done}, 2'b00);

        // 5: zero repetitions
        run(8'hFF, 4'd0, '0, '0, 1'b0, 10, d_at, c_n, b_n, cap);
        chk("s5_nbits", c_n, 0);
        chk("s5_done_at", d_at, 1);
        chk("s5_busy_cycles", b_n, 1);

        // 6: asynchronous reset after the 4th bit, then a clean restart
        run(8'h96, 4'd1, '0, '0, 1'b0, 4, d_at, c_n, b_n, cap);
        chk("s6_partial_bits", cap[3:0], 4'b1001);
        chk("s6_busy_before_reset", busy, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        chk("s6_async_reset", {bit_out, bit_valid, busy, done}, 4'b0000);
        @(posedge clk);
        #1;
        reset = 1'b0;
        run(8'h96, 4'd1, '0, '0, 1'b0, 40, d_at, c_n, b_n, cap);
        chk("s6_restart_bits", cap[7:0], 8'h96);
        chk("s6_restart_done_at", d_at, 9);

        // max repeat count
        run(8'h5A, 4'd15, '0, '0, 1'b0, 200, d_at, c_n, b_n, cap);
        chk("max_reps_nbits", c_n, 120);
        chk("max_reps_done_at", d_at, 121);

        // randomised runs, checked by the per-cycle model
        for (int t = 0; t < 30; t++) begin
            logic [WIDTH-1:0]  rp;
            logic [REPS_W-1:0] rr;
            rp = WIDTH'($urandom);
            rr = REPS_W'($urandom_range(0, 6));
            run(rp, rr, '0, '0, 1'b1, 400, d_at, c_n, b_n, cap);
            chk("rand_done_seen", (d_at != 0), 1'b1);
            chk("rand_nbits", c_n, 8 * int'(rr));
            if (rr != '0) chk("rand_last_pattern", cap[7:0], rp);
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
